// File: rtl/mult_sched_pkg.sv
// Shared types and default sizing for the multiplier scheduler.
//   state_t   : scheduler FSM encoding (2 bits)
//   N_REQ_DEF : default requester count
//   WIDTH_DEF : default operand width (product is 2*WIDTH)
package mult_sched_pkg;

    localparam int unsigned N_REQ_DEF = 4;
    localparam int unsigned WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/mult_sched_if.sv
// Bus bundle between the scheduler, its requesters and the shared multiplier.
//   requester side : req_valid/req_a/req_b -> req_ready, rsp_valid/rsp_id/rsp_p
//   multiplier side: mult_start/mult_a/mult_b -> mult_done/mult_p
//   status         : busy
// Modports: slave = scheduler view, master = environment (requesters + multiplier).
interface mult_sched_if
    import mult_sched_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF
);
    localparam int unsigned ID_W = $clog2(N_REQ);
    localparam int unsigned PW   = 2 * WIDTH;

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0]       rsp_valid;
    logic [ID_W-1:0]        rsp_id;
    logic [PW-1:0]          rsp_p;
    logic                   mult_start;
    logic [WIDTH-1:0]       mult_a;
    logic [WIDTH-1:0]       mult_b;
    logic                   mult_done;
    logic [PW-1:0]          mult_p;
    logic                   busy;

    modport slave (
        input  req_valid, req_a, req_b, mult_done, mult_p,
        output req_ready, rsp_valid, rsp_id, rsp_p, mult_start, mult_a, mult_b, busy
    );

    modport master (
        output req_valid, req_a, req_b, mult_done, mult_p,
        input  req_ready, rsp_valid, rsp_id, rsp_p, mult_start, mult_a, mult_b, busy
    );

endinterface

// File: rtl/mult_sched_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
//   i_req   : request vector
//   i_ptr   : highest-priority index
//   o_gnt_c : one-hot grant (zero when no request)
//   o_idx_c : encoded grant index
//   o_any_c : at least one request present
module mult_sched_rr_arbiter #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_gnt_c,
    output logic [ID_W-1:0]  o_idx_c,
    output logic             o_any_c
);

    logic [ID_W-1:0] w_slot;

    // Scan from the pointer upward; the first hit wins.
    always_comb begin
        o_gnt_c = '0;
        o_idx_c = '0;
        o_any_c = 1'b0;
        w_slot  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_slot = ID_W'((32'(i_ptr) + k) % N_REQ);
            if (!o_any_c && i_req[w_slot]) begin
                o_any_c         = 1'b1;
                o_gnt_c[w_slot] = 1'b1;
                o_idx_c         = w_slot;
            end
        end
    end

endmodule

// File: rtl/mult_sched.sv
// Shares one sequential multiplier among N_REQ requesters, one job in flight.
//   clk   : rising-edge clock
//   clr_n : synchronous active-low reset
//   bus   : mult_sched_if.slave (requests, tagged responses, multiplier handshake, busy)
// Optional: define ZERO_BYPASS_EN to answer zero-operand requests without the multiplier.
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic        clk,
    input  logic        clr_n,
    mult_sched_if.slave bus
);

    localparam int unsigned ID_W = $clog2(N_REQ);
    localparam int unsigned PW   = 2 * WIDTH;

    state_t             r_state;
    state_t             w_next_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [WIDTH-1:0]   r_a_q;
    logic [WIDTH-1:0]   r_b_q;
    logic [ID_W-1:0]    r_id_q;
    logic [PW-1:0]      r_p_q;
    logic               r_mult_start;
    logic               r_busy;
    logic [N_REQ-1:0]   r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [PW-1:0]      r_rsp_p;

    logic [N_REQ-1:0]   w_gnt;
    logic [ID_W-1:0]    w_idx;
    logic               w_any;
    logic [WIDTH-1:0]   w_win_a;
    logic [WIDTH-1:0]   w_win_b;
    logic [N_REQ-1:0]   w_ready_c;
    logic               w_accept_c;
    logic               w_load_p_c;
    logic               w_zero_c;

    mult_sched_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .i_req   (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .o_gnt_c (w_gnt),
        .o_idx_c (w_idx),
        .o_any_c (w_any)
    );

    assign w_win_a = bus.req_a[32'(w_idx) * WIDTH +: WIDTH];
    assign w_win_b = bus.req_b[32'(w_idx) * WIDTH +: WIDTH];

    // Next-state and accept decode.
    always_comb begin
        w_next_state = r_state;
        w_ready_c    = '0;
        w_accept_c   = 1'b0;
        w_load_p_c   = 1'b0;
        w_zero_c     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_ready_c  = w_gnt;
                    w_accept_c = 1'b1;
`ifdef ZERO_BYPASS_EN
                    if (w_win_a == '0 || w_win_b == '0) begin
                        w_zero_c     = 1'b1;
                        w_next_state = RESP;
                    end else begin
                        w_next_state = ISSUE;
                    end
`else
                    w_next_state = ISSUE;
`endif
                end
            end
            ISSUE: w_next_state = WAIT;
            WAIT: begin
                if (bus.mult_done) begin
                    w_load_p_c   = 1'b1;
                    w_next_state = RESP;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State, job registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_a_q        <= '0;
            r_b_q        <= '0;
            r_id_q       <= '0;
            r_p_q        <= '0;
            r_mult_start <= 1'b0;
            r_busy       <= 1'b0;
            r_rsp_valid  <= '0;
            r_rsp_id     <= '0;
            r_rsp_p      <= '0;
        end else begin
            r_state      <= w_next_state;
            r_mult_start <= (w_next_state == ISSUE);
            r_busy       <= (w_next_state != IDLE);

            if (w_accept_c) begin
                r_id_q <= w_idx;
            end

            // Operand registers double as mult_a/mult_b: loaded on issue, held through WAIT.
            if (w_next_state == ISSUE) begin
                r_a_q <= w_win_a;
                r_b_q <= w_win_b;
            end else if (w_next_state != WAIT) begin
                r_a_q <= '0;
                r_b_q <= '0;
            end

            if (w_load_p_c) begin
                r_p_q <= bus.mult_p;
            end else if (w_zero_c) begin
                r_p_q <= '0;
            end

            // Response is loaded in RESP and presented the following cycle.
            if (r_state == RESP) begin
                r_rsp_valid <= N_REQ'(1) << r_id_q;
                r_rsp_id    <= r_id_q;
                r_rsp_p     <= r_p_q;
                r_rr_ptr    <= (r_id_q == ID_W'(N_REQ - 1)) ? '0 : r_id_q + ID_W'(1);
            end else begin
                r_rsp_valid <= '0;
                r_rsp_id    <= '0;
                r_rsp_p     <= '0;
            end
        end
    end

    assign bus.req_ready  = w_ready_c;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_p      = r_rsp_p;
    assign bus.mult_start = r_mult_start;
    assign bus.mult_a     = r_a_q;
    assign bus.mult_b     = r_b_q;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_mult_sched.sv
// Self-checking bench for mult_sched with a behavioural L-cycle multiplier.
module tb_mult_sched;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4;
    localparam int L = 5;
`ifdef ZERO_BYPASS_EN
    localparam int ZLAT    = 2;
    localparam int ZSTARTS = 0;
`else
    localparam int ZLAT    = L + 3;
    localparam int ZSTARTS = 1;
`endif

    typedef struct {int id; int cyc; logic [N-1:0] mask;} acc_t;
    typedef struct {logic [N-1:0] vec; logic [1:0] id; logic [7:0] p; int cyc;} rsp_t;
    typedef struct {int id; logic [7:0] p; int lat;} exp_t;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    mult_sched_if #(.N_REQ(N), .WIDTH(W)) bus_if ();

    mult_sched #(.N_REQ(N), .WIDTH(W)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus_if)
    );

    // Behavioural multiplier: done L cycles after the start cycle, product from held operands.
    int   k = 0;
    logic spur = 1'b0;
    logic model_done;
    always @(posedge clk) begin
        if (!clr_n)                 k <= 0;
        else if (bus_if.mult_start) k <= L;
        else if (k > 0)             k <= k - 1;
    end
    assign model_done       = (k == 1);
    assign bus_if.mult_done = model_done | spur;
    assign bus_if.mult_p    = model_done ? ({4'b0, bus_if.mult_a} * {4'b0, bus_if.mult_b}) : 8'h00;

    int   cyc = 0;
    int   n_start = 0;
    int   n_pass = 0;
    int   n_total = 0;
    logic [N-1:0] hold_mask = '0;
    acc_t acc_log[$];
    rsp_t rsp_log[$];
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder: accepts, responses and start pulses.
    always @(negedge clk) begin
        logic [N-1:0] m;
        m = bus_if.req_valid & bus_if.req_ready;
        if (|m) begin
            int id;
            id = 0;
            for (int i = N - 1; i >= 0; i--) if (m[i]) id = i;
            acc_log.push_back('{id: id, cyc: cyc, mask: bus_if.req_ready});
        end
        if (|bus_if.rsp_valid)
            rsp_log.push_back('{vec: bus_if.rsp_valid, id: bus_if.rsp_id, p: bus_if.rsp_p, cyc: cyc});
        if (bus_if.mult_start) n_start++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock; requesters drop valid after acceptance unless held.
    task automatic step();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = bus_if.req_valid & bus_if.req_ready;
        @(posedge clk);
        #1;
        bus_if.req_valid = bus_if.req_valid & ~(acc & ~hold_mask);
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b);
        bus_if.req_a[i*W +: W] = a;
        bus_if.req_b[i*W +: W] = b;
        bus_if.req_valid[i]    = 1'b1;
    endtask

    task automatic wait_rsp(input int n, input int budget, output bit ok);
        int c;
        c = 0;
        while (rsp_log.size() < n && c < budget) begin
            step();
            c++;
        end
        ok = (rsp_log.size() >= n);
    endtask

    task automatic test_reset();
        bit ok;
        int c;
        @(negedge clk);
        n_total++;
        if ({bus_if.req_ready, bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_p, bus_if.mult_start,
             bus_if.mult_a, bus_if.mult_b, bus_if.busy} !== '0)
            $display("FAIL reset_state: outputs got %h expected 0", {bus_if.req_ready, bus_if.rsp_valid,
                     bus_if.rsp_id, bus_if.rsp_p, bus_if.mult_start, bus_if.mult_a, bus_if.mult_b, bus_if.busy});
        else n_pass++;
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        set_req(0, 4'd3, 4'd5);
        c = n_start;
        for (int i = 0; i < 10 && n_start == c; i++) step();
        step();
        step();
        clr_n = 1'b0;
        bus_if.req_valid = '0;
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        @(negedge clk);
        n_total++;
        if ({bus_if.req_ready, bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_p, bus_if.mult_start,
             bus_if.mult_a, bus_if.mult_b, bus_if.busy} !== '0)
            $display("FAIL reset_mid_wait: outputs got %h expected 0", {bus_if.req_ready, bus_if.rsp_valid,
                     bus_if.rsp_id, bus_if.rsp_p, bus_if.mult_start, bus_if.mult_a, bus_if.mult_b, bus_if.busy});
        else n_pass++;
        @(posedge clk);
        #1;
        repeat (L + 6) step();
        n_total++;
        if (rsp_log.size() !== 0) $display("FAIL reset_no_rsp: responses got %0d expected 0", rsp_log.size());
        else n_pass++;
        acc_log.delete();
        rsp_log.delete();
        set_req(3, 4'd6, 4'd7);
        exp_q.push_back('{id: 3, p: 8'd42, lat: L + 3});
        wait_rsp(1, 40, ok);
        n_total++;
        if (!ok) $display("FAIL reset_fresh_timeout: responses got %0d expected 1", rsp_log.size());
        else n_pass++;
        while (exp_q.size() > 0 && rsp_log.size() > 0 && acc_log.size() > 0) begin
            exp_t e; acc_t a; rsp_t r; logic [N-1:0] one;
            e = exp_q.pop_front(); a = acc_log.pop_front(); r = rsp_log.pop_front();
            one = 1 << e.id;
            n_total++; if (a.mask !== one) $display("FAIL reset_fresh ready: got %b expected %b", a.mask, one); else n_pass++;
            n_total++; if (r.vec !== one) $display("FAIL reset_fresh rsp_valid: got %b expected %b", r.vec, one); else n_pass++;
            n_total++; if (r.id !== 2'(e.id)) $display("FAIL reset_fresh id: got %0d expected %0d", r.id, e.id); else n_pass++;
            n_total++; if (r.p !== e.p) $display("FAIL reset_fresh p: got %0d expected %0d", r.p, e.p); else n_pass++;
            n_total++; if (r.cyc - a.cyc !== e.lat) $display("FAIL reset_fresh latency: got %0d expected %0d", r.cyc - a.cyc, e.lat); else n_pass++;
        end
        exp_q.delete();
    endtask

    task automatic test_all_four();
        bit ok;
        int s0;
        s0 = n_start;
        set_req(0, 4'd4, 4'd7);
        set_req(1, 4'd15, 4'd15);
        set_req(2, 4'd3, 4'd3);
        set_req(3, 4'd1, 4'd9);
        exp_q.push_back('{id: 0, p: 8'd28,  lat: L + 3});
        exp_q.push_back('{id: 1, p: 8'd225, lat: L + 3});
        exp_q.push_back('{id: 2, p: 8'd9,   lat: L + 3});
        exp_q.push_back('{id: 3, p: 8'd9,   lat: L + 3});
        wait_rsp(4, 100, ok);
        n_total++;
        if (!ok) $display("FAIL all_four_timeout: responses got %0d expected 4", rsp_log.size()); else n_pass++;
        n_total++;
        if (n_start - s0 !== 4) $display("FAIL all_four_starts: got %0d expected 4", n_start - s0); else n_pass++;
        while (exp_q.size() > 0 && rsp_log.size() > 0 && acc_log.size() > 0) begin
            exp_t e; acc_t a; rsp_t r; logic [N-1:0] one;
            e = exp_q.pop_front(); a = acc_log.pop_front(); r = rsp_log.pop_front();
            one = 1 << e.id;
            n_total++; if (a.mask !== one) $display("FAIL all_four ready: got %b expected %b", a.mask, one); else n_pass++;
            n_total++; if (r.vec !== one) $display("FAIL all_four rsp_valid: got %b expected %b", r.vec, one); else n_pass++;
            n_total++; if (r.id !== 2'(e.id)) $display("FAIL all_four id: got %0d expected %0d", r.id, e.id); else n_pass++;
            n_total++; if (r.p !== e.p) $display("FAIL all_four p: got %0d expected %0d", r.p, e.p); else n_pass++;
            n_total++; if (r.cyc - a.cyc !== e.lat) $display("FAIL all_four latency: got %0d expected %0d", r.cyc - a.cyc, e.lat); else n_pass++;
        end
        exp_q.delete();
    endtask

    task automatic test_single();
        bit ok;
        int s0;
        s0 = n_start;
        set_req(0, 4'd2, 4'd4);
        exp_q.push_back('{id: 0, p: 8'd8, lat: L + 3});
        wait_rsp(1, 40, ok);
        n_total++;
        if (!ok) $display("FAIL single_timeout: responses got %0d expected 1", rsp_log.size()); else n_pass++;
        n_total++;
        if (n_start - s0 !== 1) $display("FAIL single_starts: got %0d expected 1", n_start - s0); else n_pass++;
        while (exp_q.size() > 0 && rsp_log.size() > 0 && acc_log.size() > 0) begin
            exp_t e; acc_t a; rsp_t r; logic [N-1:0] one;
            e = exp_q.pop_front(); a = acc_log.pop_front(); r = rsp_log.pop_front();
            one = 1 << e.id;
            n_total++; if (a.mask !== one) $display("FAIL single ready: got %b expected %b", a.mask, one); else n_pass++;
            n_total++; if (r.vec !== one) $display("FAIL single rsp_valid: got %b expected %b", r.vec, one); else n_pass++;
            n_total++; if (r.id !== 2'(e.id)) $display("FAIL single id: got %0d expected %0d", r.id, e.id); else n_pass++;
            n_total++; if (r.p !== e.p) $display("FAIL single p: got %0d expected %0d", r.p, e.p); else n_pass++;
            n_total++; if (r.cyc - a.cyc !== e.lat) $display("FAIL single latency: got %0d expected %0d", r.cyc - a.cyc, e.lat); else n_pass++;
        end
        exp_q.delete();
    endtask

    task automatic test_starvation();
        bit ok;
        int c;
        hold_mask = 4'b1010;
        set_req(1, 4'd5, 4'd6);
        set_req(3, 4'd9, 4'd11);
        exp_q.push_back('{id: 1, p: 8'd30, lat: L + 3});
        exp_q.push_back('{id: 3, p: 8'd99, lat: L + 3});
        exp_q.push_back('{id: 1, p: 8'd30, lat: L + 3});
        exp_q.push_back('{id: 3, p: 8'd99, lat: L + 3});
        c = 0;
        while (acc_log.size() < 4 && c < 100) begin
            step();
            c++;
        end
        hold_mask = '0;
        bus_if.req_valid = '0;
        wait_rsp(4, 40, ok);
        n_total++;
        if (!ok) $display("FAIL starve_timeout: responses got %0d expected 4", rsp_log.size()); else n_pass++;
        while (exp_q.size() > 0 && rsp_log.size() > 0 && acc_log.size() > 0) begin
            exp_t e; acc_t a; rsp_t r; logic [N-1:0] one;
            e = exp_q.pop_front(); a = acc_log.pop_front(); r = rsp_log.pop_front();
            one = 1 << e.id;
            n_total++; if (a.mask !== one) $display("FAIL starve ready: got %b expected %b", a.mask, one); else n_pass++;
            n_total++; if (r.vec !== one) $display("FAIL starve rsp_valid: got %b expected %b", r.vec, one); else n_pass++;
            n_total++; if (r.id !== 2'(e.id)) $display("FAIL starve id: got %0d expected %0d", r.id, e.id); else n_pass++;
            n_total++; if (r.p !== e.p) $display("FAIL starve p: got %0d expected %0d", r.p, e.p); else n_pass++;
            n_total++; if (r.cyc - a.cyc !== e.lat) $display("FAIL starve latency: got %0d expected %0d", r.cyc - a.cyc, e.lat); else n_pass++;
        end
        exp_q.delete();
        acc_log.delete();
        rsp_log.delete();
    endtask

    task automatic test_spurious_done();
        bit ok;
        repeat (3) step();
        spur = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_total++;
            if ({bus_if.busy, bus_if.rsp_valid, bus_if.mult_start} !== '0)
                $display("FAIL spurious_done cycle %0d: busy/rsp/start got %b expected 0", c,
                         {bus_if.busy, bus_if.rsp_valid, bus_if.mult_start});
            else n_pass++;
            @(posedge clk);
            #1;
            spur = 1'b0;
        end
        set_req(1, 4'd7, 4'd8);
        exp_q.push_back('{id: 1, p: 8'd56, lat: L + 3});
        wait_rsp(1, 40, ok);
        n_total++;
        if (!ok) $display("FAIL spurious_after_timeout: responses got %0d expected 1", rsp_log.size()); else n_pass++;
        while (exp_q.size() > 0 && rsp_log.size() > 0 && acc_log.size() > 0) begin
            exp_t e; acc_t a; rsp_t r; logic [N-1:0] one;
            e = exp_q.pop_front(); a = acc_log.pop_front(); r = rsp_log.pop_front();
            one = 1 << e.id;
            n_total++; if (a.mask !== one) $display("FAIL spurious_after ready: got %b expected %b", a.mask, one); else n_pass++;
            n_total++; if (r.id !== 2'(e.id)) $display("FAIL spurious_after id: got %0d expected %0d", r.id, e.id); else n_pass++;
            n_total++; if (r.p !== e.p) $display("FAIL spurious_after p: got %0d expected %0d", r.p, e.p); else n_pass++;
            n_total++; if (r.cyc - a.cyc !== e.lat) $display("FAIL spurious_after latency: got %0d expected %0d", r.cyc - a.cyc, e.lat); else n_pass++;
        end
        exp_q.delete();
    endtask

    task automatic test_zero_operand();
        bit ok;
        int s0;
        s0 = n_start;
        set_req(2, 4'd0, 4'd9);
        exp_q.push_back('{id: 2, p: 8'd0, lat: ZLAT});
        wait_rsp(1, 40, ok);
        n_total++;
        if (!ok) $display("FAIL zero_timeout: responses got %0d expected 1", rsp_log.size()); else n_pass++;
        repeat (2) step();
        n_total++;
        if (n_start - s0 !== ZSTARTS) $display("FAIL zero_starts: got %0d expected %0d", n_start - s0, ZSTARTS); else n_pass++;
        while (exp_q.size() > 0 && rsp_log.size() > 0 && acc_log.size() > 0) begin
            exp_t e; acc_t a; rsp_t r; logic [N-1:0] one;
            e = exp_q.pop_front(); a = acc_log.pop_front(); r = rsp_log.pop_front();
            one = 1 << e.id;
            n_total++; if (r.vec !== one) $display("FAIL zero rsp_valid: got %b expected %b", r.vec, one); else n_pass++;
            n_total++; if (r.id !== 2'(e.id)) $display("FAIL zero id: got %0d expected %0d", r.id, e.id); else n_pass++;
            n_total++; if (r.p !== e.p) $display("FAIL zero p: got %0d expected %0d", r.p, e.p); else n_pass++;
            n_total++; if (r.cyc - a.cyc !== e.lat) $display("FAIL zero latency: got %0d expected %0d", r.cyc - a.cyc, e.lat); else n_pass++;
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int c;
        hold_mask = 4'b0001;
        set_req(0, 4'd3, 4'd3);
        exp_q.push_back('{id: 0, p: 8'd9, lat: L + 3});
        exp_q.push_back('{id: 0, p: 8'd9, lat: L + 3});
        c = 0;
        while (acc_log.size() < 2 && c < 60) begin
            step();
            c++;
        end
        hold_mask = '0;
        bus_if.req_valid = '0;
        n_total++;
        if (acc_log.size() < 2) $display("FAIL b2b_accepts: got %0d expected 2", acc_log.size());
        else if (acc_log[1].cyc - acc_log[0].cyc !== L + 3)
            $display("FAIL b2b_spacing: got %0d expected %0d", acc_log[1].cyc - acc_log[0].cyc, L + 3);
        else n_pass++;
        wait_rsp(2, 40, ok);
        n_total++;
        if (!ok) $display("FAIL b2b_timeout: responses got %0d expected 2", rsp_log.size()); else n_pass++;
        while (exp_q.size() > 0 && rsp_log.size() > 0 && acc_log.size() > 0) begin
            exp_t e; acc_t a; rsp_t r;
            e = exp_q.pop_front(); a = acc_log.pop_front(); r = rsp_log.pop_front();
            n_total++; if (r.id !== 2'(e.id)) $display("FAIL b2b id: got %0d expected %0d", r.id, e.id); else n_pass++;
            n_total++; if (r.p !== e.p) $display("FAIL b2b p: got %0d expected %0d", r.p, e.p); else n_pass++;
            n_total++; if (r.cyc - a.cyc !== e.lat) $display("FAIL b2b latency: got %0d expected %0d", r.cyc - a.cyc, e.lat); else n_pass++;
        end
        exp_q.delete();
    endtask

    initial begin
        bus_if.req_valid = '0;
        bus_if.req_a     = '0;
        bus_if.req_b     = '0;
        clr_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_all_four();
        test_single();
        test_starvation();
        test_spurious_done();
        test_zero_operand();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
